k423_mem_stage: RTL and testbench
=================================

# k423_mem_stage

Memory-access stage of the k423 in-order pipeline. It sits between the ex/mem pipeline register and `k423_pipe_mem_wb`. It issues load/store requests to the data-memory port, aligns and sign-extends load data, and passes non-memory instructions through. It drives `mem_stage_vld`, `mem_pc`, `mem_rd_*` toward the mem/wb register and honours `wb_stage_rdy` backpressure.

## Interface
Parameters:
- None. Widths come from `CORE_XLEN` (32), `CORE_ADDR_W` (32) and `INST_RSDIDX_W` (5) in `k423_defines.svh`.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low; clock clk_i
- ex2mem_stage_vld_i  in  1  upstream instruction valid
- mem_stage_rdy_o  out  1  instruction retired this cycle; upstream may advance
- mem_pc_i  in  ADDR_W  instruction PC
- mem_rd_vld_i / mem_rd_idx_i  in  1 / RSDIDX_W  destination write enable / index
- mem_alu_i  in  XLEN  ALU result; effective address for memory ops
- mem_sdata_i  in  XLEN  store data (rs2)
- mem_lsu_op_i  in  4  {is_mem, funct3}; is_mem=0 means non-memory
- mem_is_store_i  in  1  1=store, 0=load (valid when is_mem)
- dmem_req_vld_o / dmem_req_rdy_i  out / in  1  request handshake
- dmem_req_addr_o  out  ADDR_W  word-aligned address ({addr[31:2],2'b0})
- dmem_req_we_o  out  1  write
- dmem_req_wdata_o / dmem_req_wstrb_o  out  XLEN / 4  store data / byte strobes
- dmem_rsp_vld_i / dmem_rsp_rdata_i  in  1 / XLEN  load response (no ready; always accepted)
- mem_stage_vld_o  out  1  to mem/wb `mem_stage_vld_i`
- wb_stage_rdy_i  in  1  downstream ready
- mem_pc_o / mem_rd_vld_o / mem_rd_idx_o / mem_rd_o  out  to mem/wb
- mem_misalign_o  out  1  misaligned-access flag, qualified by mem_stage_vld_o

## Operation
- FSM states: IDLE, WAIT_RSP, HOLD.
- IDLE, non-memory op with vld:
  - mem_stage_vld_o=1, mem_rd_o=mem_alu_i, mem_stage_rdy_o=wb_stage_rdy_i.
  - Stays in IDLE; the op is held upstream until wb is ready.
- IDLE, memory op: dmem_req_vld_o=1, combinational from the inputs.
  - Store handshake (`req_vld & req_rdy`): retire in the same cycle.
    - mem_stage_vld_o=1, mem_rd_vld_o=0.
    - If wb_stage_rdy_i=0, capture into the hold register and go to HOLD.
  - Load handshake: go to WAIT_RSP. The op type, addr[1:0] and PC/rd fields are latched.
- WAIT_RSP: on dmem_rsp_vld_i, format the data and assert mem_stage_vld_o.
  - mem_stage_rdy_o=wb_stage_rdy_i.
  - wb ready: retire and go to IDLE.
  - wb not ready: capture into the hold register and go to HOLD.
- HOLD: outputs come from the hold register; mem_stage_vld_o=1. On wb_stage_rdy_i, assert mem_stage_rdy_o=1 and go to IDLE.
- mem_stage_rdy_o is 0 in every cycle in which no retirement happens. Upstream keeps its inputs stable until it sees mem_stage_rdy_o.
- Load formatting, with byte lane selected by addr[1:0]:
  - LB (000) / LBU (100): sign- / zero-extend the selected byte.
  - LH (001) / LHU (101): lane addr[1]; sign- / zero-extend.
  - LW (010): the full word.
- Store alignment:
  - SB: wdata={4{b}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - SW: wstrb=4'b1111.
- dmem_rsp_vld_i outside WAIT_RSP is ignored.

## Timing
- Reset: state=IDLE, hold registers=0. Outputs are combinational, so with ex2mem_stage_vld_i=0 every output is 0.
- Non-memory op: 0-cycle pass-through.
- Store: retires in the request-handshake cycle.
- Load: retires in the response cycle. Minimum latency is 1 cycle after the request handshake.
- Response and wb_stage_rdy_i in the same cycle: zero-bubble retire. Back-to-back memory ops are allowed: a new request may be issued in the IDLE cycle after a retire.
- Async reset mid-transaction returns to IDLE and drops the outstanding response. The data-memory port must share the reset.

## Configuration
- `K423_LSU_MISALIGN_CHK_EN` defined:
  - A misaligned access is LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0.
  - It issues no bus request. It retires in IDLE with mem_misalign_o=1 and mem_rd_vld_o=0.
  - It goes through HOLD if wb is not ready.
- Macro undefined:
  - mem_misalign_o is tied to 0.
  - Offending low bits are ignored: halfword uses addr[1] only, word uses addr[31:2].
  - The access proceeds normally.

## Structure
- Shared package `k423_pkg`:
  - `lsu_op_e` for the funct3 encodings.
  - `mem_state_e`.
  - The constant `DMEM_STRB_W`=4.
- Sub-module `k423_lsu_fmt`: combinational store-data/strobe alignment and load extract/extend, instantiated once.

## Test plan
- ADD, mem_alu_i=0x1234, wb ready -> same cycle: vld=1, rd_o=0x1234, rdy_o=1, no dmem request.
- SB, addr 0x1003, sdata 0xAB -> wdata=0xABABABAB, wstrb=0x8, addr 0x1000, we=1; retires in the handshake cycle.
- LB, addr 0x2002, rdata 0x00800000 -> rd_o=0xFFFFFF80. The same access as LBU -> 0x00000080.
- LW; wb_stage_rdy_i=0 for 3 cycles from the response -> HOLD holds rd_o stable; rdy_o rises in the cycle wb_stage_rdy_i=1.
- LH at addr 0x3001 with the macro -> no request, misalign_o=1, rd_vld_o=0. Without the macro -> request issued; rd_o = sign-extended rdata[15:0].
- rst_n_i asserted in WAIT_RSP, then a late rsp_vld -> state is IDLE, all outputs 0, the response is ignored.

Source files
------------

// File: rtl/k423_pkg.sv
// k423_pkg: shared widths, LSU funct3 encodings and mem-stage FSM states.
package k423_pkg;
   localparam int CORE_XLEN = 32;
   localparam int CORE_ADDR_W = 32;
   localparam int INST_RSDIDX_W = 5;
   localparam int DMEM_STRB_W = 4;
   typedef enum logic [2:0] {
      LSU_B  = 3'b000,
      LSU_H  = 3'b001,
      LSU_W  = 3'b010,
      LSU_BU = 3'b100,
      LSU_HU = 3'b101
   } lsu_op_e;
   typedef enum logic [1:0] {IDLE, WAIT_RSP, HOLD} mem_state_e;
   function automatic logic misaligned(input lsu_op_e op, input logic [1:0] lo);
      return ((op == LSU_H || op == LSU_HU) && lo[0]) || (op == LSU_W && lo != 2'b00);
   endfunction
endpackage

// File: rtl/k423_mem_stage_if.sv
// k423_mem_stage_if: data-memory request/response port of the k423 mem stage.
interface k423_mem_stage_if;
   import k423_pkg::*;
   logic                   req_vld;
   logic                   req_rdy;
   logic [CORE_ADDR_W-1:0] req_addr;
   logic                   req_we;
   logic [CORE_XLEN-1:0]   req_wdata;
   logic [DMEM_STRB_W-1:0] req_wstrb;
   logic                   rsp_vld;
   logic [CORE_XLEN-1:0]   rsp_rdata;
   modport master (output req_vld, req_addr, req_we, req_wdata, req_wstrb,
                   input  req_rdy, rsp_vld, rsp_rdata);
   modport slave  (input  req_vld, req_addr, req_we, req_wdata, req_wstrb,
                   output req_rdy, rsp_vld, rsp_rdata);
endinterface

// File: rtl/k423_lsu_fmt.sv
// k423_lsu_fmt: store data/strobe lane replication and load byte/half extract with sign/zero extension.
module k423_lsu_fmt
   import k423_pkg::*;
(
   input  lsu_op_e                op,
   input  logic [1:0]             lo,
   input  logic [CORE_XLEN-1:0]   sdata,
   input  logic [CORE_XLEN-1:0]   rdata,
   output logic [CORE_XLEN-1:0]   wdata,
   output logic [DMEM_STRB_W-1:0] wstrb,
   output logic [CORE_XLEN-1:0]   ldata
);
   logic       is_w, is_h, sx;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   always_comb begin
      is_w   = op == LSU_W;
      is_h   = op == LSU_H || op == LSU_HU;
      sx     = !op[2];
      byte_v = 8'(rdata >> {lo, 3'b000});
      half_v = lo[1] ? rdata[31:16] : rdata[15:0];
      ldata  = is_w ? rdata : is_h ? {{16{sx & half_v[15]}}, half_v} : {{24{sx & byte_v[7]}}, byte_v};
      wdata  = is_w ? sdata : is_h ? {2{sdata[15:0]}} : {4{sdata[7:0]}};
      wstrb  = is_w ? 4'b1111 : is_h ? 4'b0011 << {lo[1], 1'b0} : 4'b0001 << lo;
   end
endmodule

// File: rtl/k423_mem_stage.sv
// k423_mem_stage: k423 memory-access stage; issues dmem requests, formats loads, passes ALU ops through.
// K423_LSU_MISALIGN_CHK_EN: flag misaligned half/word accesses instead of issuing them.
module k423_mem_stage
   import k423_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     ex2mem_stage_vld_i,
   output logic                     mem_stage_rdy_o,
   input  logic [CORE_ADDR_W-1:0]   mem_pc_i,
   input  logic                     mem_rd_vld_i,
   input  logic [INST_RSDIDX_W-1:0] mem_rd_idx_i,
   input  logic [CORE_XLEN-1:0]     mem_alu_i,
   input  logic [CORE_XLEN-1:0]     mem_sdata_i,
   input  logic [3:0]               mem_lsu_op_i,
   input  logic                     mem_is_store_i,
   k423_mem_stage_if.master         dmem,
   output logic                     mem_stage_vld_o,
   input  logic                     wb_stage_rdy_i,
   output logic [CORE_ADDR_W-1:0]   mem_pc_o,
   output logic                     mem_rd_vld_o,
   output logic [INST_RSDIDX_W-1:0] mem_rd_idx_o,
   output logic [CORE_XLEN-1:0]     mem_rd_o,
   output logic                     mem_misalign_o
);
   mem_state_e                 st, nxt;
   logic [CORE_ADDR_W-1:0]     pc_q;
   logic                       rd_vld_q, mis_q;
   logic [INST_RSDIDX_W-1:0]   rd_idx_q;
   logic [CORE_XLEN-1:0]       rd_q;
   lsu_op_e                    op_q, op;
   logic [1:0]                 lo_q, lo;
   logic                       is_mem, mis, hs, lat, cap;
   logic [CORE_XLEN-1:0]       wdata, ldata;
   logic [DMEM_STRB_W-1:0]     wstrb;

   assign is_mem = mem_lsu_op_i[3];
`ifdef K423_LSU_MISALIGN_CHK_EN
   assign mis = is_mem && misaligned(lsu_op_e'(mem_lsu_op_i[2:0]), mem_alu_i[1:0]);
`else
   assign mis = 1'b0;
`endif
   // the formatter serves stores from live inputs and loads from the latched request
   assign op = st == WAIT_RSP ? op_q : lsu_op_e'(mem_lsu_op_i[2:0]);
   assign lo = st == WAIT_RSP ? lo_q : mem_alu_i[1:0];

   assign dmem.req_vld   = st == IDLE && ex2mem_stage_vld_i && is_mem && !mis;
   assign hs             = dmem.req_vld && dmem.req_rdy;
   assign dmem.req_addr  = dmem.req_vld ? {mem_alu_i[CORE_ADDR_W-1:2], 2'b00} : '0;
   assign dmem.req_we    = dmem.req_vld && mem_is_store_i;
   assign dmem.req_wdata = dmem.req_we ? wdata : '0;
   assign dmem.req_wstrb = dmem.req_we ? wstrb : '0;

   k423_lsu_fmt u_fmt (
      .op    (op),
      .lo    (lo),
      .sdata (mem_sdata_i),
      .rdata (dmem.rsp_rdata),
      .wdata (wdata),
      .wstrb (wstrb),
      .ldata (ldata)
   );

   always_comb begin
      nxt             = st;
      mem_stage_vld_o = 1'b0;
      mem_stage_rdy_o = 1'b0;
      mem_pc_o        = '0;
      mem_rd_vld_o    = 1'b0;
      mem_rd_idx_o    = '0;
      mem_rd_o        = '0;
      mem_misalign_o  = 1'b0;
      lat             = 1'b0;
      cap             = 1'b0;
      if (st == IDLE) begin
         if (ex2mem_stage_vld_i && (!is_mem || mis || (hs && mem_is_store_i))) begin
            mem_stage_vld_o = 1'b1;
            mem_stage_rdy_o = wb_stage_rdy_i;
            mem_pc_o        = mem_pc_i;
            mem_rd_vld_o    = mem_rd_vld_i && !is_mem;
            mem_rd_idx_o    = mem_rd_idx_i;
            mem_rd_o        = mem_alu_i;
            mem_misalign_o  = mis;
            cap             = is_mem && !wb_stage_rdy_i;
            nxt             = cap ? HOLD : IDLE;
         end else if (hs) begin
            lat = 1'b1;
            nxt = WAIT_RSP;
         end
      end else if (st == HOLD || dmem.rsp_vld) begin
         mem_stage_vld_o = 1'b1;
         mem_stage_rdy_o = wb_stage_rdy_i;
         mem_pc_o        = pc_q;
         mem_rd_vld_o    = rd_vld_q;
         mem_rd_idx_o    = rd_idx_q;
         mem_rd_o        = st == HOLD ? rd_q : ldata;
         mem_misalign_o  = st == HOLD && mis_q;
         cap             = st == WAIT_RSP && !wb_stage_rdy_i;
         nxt             = wb_stage_rdy_i ? IDLE : HOLD;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         st       <= IDLE;
         pc_q     <= '0;
         rd_vld_q <= 1'b0;
         rd_idx_q <= '0;
         rd_q     <= '0;
         mis_q    <= 1'b0;
         op_q     <= LSU_B;
         lo_q     <= '0;
      end else begin
         st <= nxt;
         if (lat) begin
            pc_q     <= mem_pc_i;
            rd_vld_q <= mem_rd_vld_i;
            rd_idx_q <= mem_rd_idx_i;
            op_q     <= op;
            lo_q     <= lo;
         end
         if (cap) begin
            pc_q     <= mem_pc_o;
            rd_vld_q <= mem_rd_vld_o;
            rd_idx_q <= mem_rd_idx_o;
            rd_q     <= mem_rd_o;
            mis_q    <= mem_misalign_o;
         end
      end
   end
endmodule

// File: tb/tb_k423_mem_stage.sv
// tb_k423_mem_stage: directed and randomized checks of k423_mem_stage against a behavioural model.
module tb_k423_mem_stage;
   import k423_pkg::*;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_vld, rdy, rd_vld_i, is_store, st_vld, wb_rdy, rd_vld_o, mis_o;
   logic [31:0] pc_i, alu, sdata, pc_o, rd_o;
   logic [4:0]  idx_i, idx_o;
   logic [3:0]  lsu_op;
   int          checks = 0;
   int          errors = 0;
   logic [2:0]  ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

   always #5 clk = ~clk;

   k423_mem_stage_if dmem();

   k423_mem_stage dut (
      .clk_i              (clk),
      .rst_n_i            (rst_n),
      .ex2mem_stage_vld_i (ex_vld),
      .mem_stage_rdy_o    (rdy),
      .mem_pc_i           (pc_i),
      .mem_rd_vld_i       (rd_vld_i),
      .mem_rd_idx_i       (idx_i),
      .mem_alu_i          (alu),
      .mem_sdata_i        (sdata),
      .mem_lsu_op_i       (lsu_op),
      .mem_is_store_i     (is_store),
      .dmem               (dmem),
      .mem_stage_vld_o    (st_vld),
      .wb_stage_rdy_i     (wb_rdy),
      .mem_pc_o           (pc_o),
      .mem_rd_vld_o       (rd_vld_o),
      .mem_rd_idx_o       (idx_o),
      .mem_rd_o           (rd_o),
      .mem_misalign_o     (mis_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, 32'(obs), 32'(exp));
   endtask

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
      logic [31:0] v;
      if (f3 == 3'b010) return d;
      if (f3[1:0] == 2'b01) begin
         v = (d >> (16 * (lo / 2))) & 32'hffff;
         if (!f3[2] && v >= 32'h8000) v -= 32'h10000;
      end else begin
         v = (d >> (8 * lo)) & 32'hff;
         if (!f3[2] && v >= 32'h80) v -= 32'h100;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
      return f3 == 3'b010 ? d : f3 == 3'b001 ? (d & 32'hffff) * 32'h00010001 : (d & 32'hff) * 32'h01010101;
   endfunction

   function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [1:0] lo);
      return f3 == 3'b010 ? 4'hf : f3 == 3'b001 ? 4'(3 << (2 * (lo / 2))) : 4'(1 << lo);
   endfunction

   function automatic logic m_mis(input logic mem, input logic [2:0] f3, input logic [1:0] lo);
`ifdef K423_LSU_MISALIGN_CHK_EN
      return mem && ((f3[1:0] == 2'b01 && lo % 2 != 0) || (f3 == 3'b010 && lo != 0));
`else
      return 1'b0;
`endif
   endfunction

   task automatic quiet(input string tag);
      @(negedge clk);
      chk1({tag, "_vld"}, st_vld, 1'b0);
      chk1({tag, "_rdy"}, rdy, 1'b0);
      chk1({tag, "_req"}, dmem.req_vld, 1'b0);
      chk({tag, "_pc"}, pc_o, 32'h0);
      chk({tag, "_rd"}, rd_o, 32'h0);
      chk({tag, "_misc"}, 32'({rd_vld_o, idx_o, mis_o, dmem.req_we, dmem.req_wstrb}), 32'h0);
      chk({tag, "_addr"}, dmem.req_addr | dmem.req_wdata, 32'h0);
      @(posedge clk); #1;
   endtask

   task automatic idle_gap();
      ex_vld = 1'b0;
      dmem.req_rdy = 1'($urandom_range(0, 1));
      dmem.rsp_vld = 1'($urandom_range(0, 1));
      wb_rdy = 1'($urandom_range(0, 1));
      quiet("idle");
   endtask

   task automatic run_op(input logic mem, input logic st, input logic [2:0] f3, input logic [31:0] pc,
                         input logic rdv, input logic [4:0] idx, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rdata, input int rq_w, input int rs_w, input int wb_w);
      logic        mis;
      logic [31:0] exp_rd;
      mis = m_mis(mem, f3, a[1:0]);
      exp_rd = m_load(f3, a[1:0], rdata);
      ex_vld = 1'b1; lsu_op = {mem, f3}; is_store = st; pc_i = pc; rd_vld_i = rdv; idx_i = idx;
      alu = a; sdata = sd; dmem.rsp_vld = 1'b0; dmem.rsp_rdata = $urandom;
      if (!mem || mis) begin
         for (int i = 0; i <= wb_w; i++) begin
            wb_rdy = i == wb_w;
            dmem.req_rdy = 1'b1;
            @(negedge clk);
            chk1("pass_vld", st_vld, 1'b1);
            chk1("pass_rdy", rdy, wb_rdy);
            chk1("pass_noreq", dmem.req_vld, 1'b0);
            chk1("pass_rdv", rd_vld_o, rdv && !mem);
            chk1("pass_mis", mis_o, mis);
            chk("pass_pc", pc_o, pc);
            chk("pass_idx", 32'(idx_o), 32'(idx));
            if (!mem) chk("pass_rd", rd_o, a);
            @(posedge clk); #1;
         end
         return;
      end
      for (int i = 0; i <= rq_w; i++) begin
         dmem.req_rdy = i == rq_w;
         wb_rdy = i == rq_w ? wb_w == 0 : 1'($urandom_range(0, 1));
         @(negedge clk);
         chk1("req_vld", dmem.req_vld, 1'b1);
         chk("req_addr", dmem.req_addr, {a[31:2], 2'b00});
         chk1("req_we", dmem.req_we, st);
         if (st) begin
            chk("req_wdata", dmem.req_wdata, m_wdata(f3, sd));
            chk("req_wstrb", 32'(dmem.req_wstrb), 32'(m_wstrb(f3, a[1:0])));
         end
         chk1("req_stvld", st_vld, st && dmem.req_rdy);
         chk1("req_rdy", rdy, st && dmem.req_rdy && wb_rdy);
         if (st && dmem.req_rdy) chk1("st_rdv", rd_vld_o, 1'b0);
         @(posedge clk); #1;
      end
      if (st) begin
         for (int i = 1; i <= wb_w; i++) begin
            wb_rdy = i == wb_w;
            dmem.req_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk1("sth_vld", st_vld, 1'b1);
            chk1("sth_rdy", rdy, wb_rdy);
            chk1("sth_noreq", dmem.req_vld, 1'b0);
            chk1("sth_rdv", rd_vld_o, 1'b0);
            chk("sth_pc", pc_o, pc);
            @(posedge clk); #1;
         end
         return;
      end
      for (int i = 0; i <= rs_w + wb_w; i++) begin
         dmem.rsp_vld = i == rs_w ? 1'b1 : i > rs_w ? 1'($urandom_range(0, 1)) : 1'b0;
         dmem.rsp_rdata = i == rs_w ? rdata : $urandom;
         dmem.req_rdy = 1'($urandom_range(0, 1));
         wb_rdy = i == rs_w + wb_w ? 1'b1 : i < rs_w ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         chk1("ld_noreq", dmem.req_vld, 1'b0);
         chk1("ld_vld", st_vld, i >= rs_w);
         chk1("ld_rdy", rdy, i >= rs_w && wb_rdy);
         if (i >= rs_w) begin
            chk("ld_rd", rd_o, exp_rd);
            chk("ld_pc", pc_o, pc);
            chk1("ld_rdv", rd_vld_o, rdv);
            chk("ld_idx", 32'(idx_o), 32'(idx));
            chk1("ld_mis", mis_o, 1'b0);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      ex_vld = 1'b0; lsu_op = 4'h0; is_store = 1'b0; pc_i = 32'h0; rd_vld_i = 1'b0; idx_i = 5'h0;
      alu = 32'h0; sdata = 32'h0; wb_rdy = 1'b0;
      dmem.req_rdy = 1'b0; dmem.rsp_vld = 1'b0; dmem.rsp_rdata = 32'h0;
      quiet("reset");
      rst_n = 1'b1;
      idle_gap();
      // directed scenarios from the bring-up list
      run_op(1'b0, 1'b0, 3'b000, 32'h100, 1'b1, 5'd3, 32'h1234, 32'h0, 32'h0, 0, 0, 0);
      run_op(1'b1, 1'b1, 3'b000, 32'h104, 1'b0, 5'd0, 32'h1003, 32'h5A5A_00AB, 32'h0, 0, 0, 0);
      run_op(1'b1, 1'b0, 3'b000, 32'h108, 1'b1, 5'd7, 32'h2002, 32'h0, 32'h0080_0000, 0, 0, 0);
      run_op(1'b1, 1'b0, 3'b100, 32'h10C, 1'b1, 5'd8, 32'h2002, 32'h0, 32'h0080_0000, 0, 0, 0);
      run_op(1'b1, 1'b0, 3'b010, 32'h110, 1'b1, 5'd9, 32'h2000, 32'h0, 32'hCAFE_F00D, 1, 2, 3);
      run_op(1'b1, 1'b0, 3'b001, 32'h114, 1'b1, 5'd10, 32'h3001, 32'h0, 32'h1234_8765, 0, 0, 0);
      run_op(1'b1, 1'b1, 3'b001, 32'h118, 1'b0, 5'd0, 32'h4002, 32'h0000_BEEF, 32'h0, 1, 0, 2);
      run_op(1'b0, 1'b0, 3'b011, 32'h11C, 1'b1, 5'd4, 32'h7777_0001, 32'h0, 32'h0, 0, 0, 2);
      // reset while a load response is outstanding
      ex_vld = 1'b1; lsu_op = 4'b1010; is_store = 1'b0; alu = 32'h5000; dmem.req_rdy = 1'b1; wb_rdy = 1'b1;
      @(negedge clk);
      chk1("rst_req", dmem.req_vld, 1'b1);
      @(posedge clk); #1;
      ex_vld = 1'b0; dmem.rsp_vld = 1'b0; dmem.req_rdy = 1'b0;
      #2 rst_n = 1'b0;
      quiet("rst_mid");
      rst_n = 1'b1;
      dmem.rsp_vld = 1'b1; dmem.rsp_rdata = 32'h1111_2222;
      quiet("late_rsp");
      run_op(1'b1, 1'b0, 3'b101, 32'h120, 1'b1, 5'd11, 32'h6002, 32'h0, 32'h9ABC_1234, 0, 1, 0);
      // randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         logic       mem, st;
         logic [2:0] f3;
         mem = $urandom_range(0, 3) != 0;
         st = 1'($urandom_range(0, 1));
         f3 = !mem ? 3'($urandom) : st ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
         run_op(mem, st, f3, $urandom, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, $urandom,
                $urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
         if ($urandom_range(0, 3) == 0) idle_gap();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
